// File: rtl/sram_word_responder.sv
// sram_word_responder
// Responder side of the LSU 32-bit data-memory request/ack interface.
// Each word access is split into two 16-bit accesses on an external
// asynchronous SRAM (256K x 16). Write halves with no enabled bytes are
// skipped. Reads always perform both halves.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for i_wren/i_rden; request latched on acceptance
// LO_SETUP  | address (and write data) for the low halfword, strobes off
// LO_STROBE | WE_N or OE_N active for the low halfword, STROBE_CYC cycles
// HI_SETUP  | address (and write data) for the high halfword, strobes off
// HI_STROBE | WE_N or OE_N active for the high halfword, STROBE_CYC cycles
// DONE      | one-cycle o_ack, SRAM deselected
module sram_word_responder #(
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  input  logic        i_wren,
  input  logic        i_rden,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic [17:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LO_SETUP  = 3'd1,
    LO_STROBE = 3'd2,
    HI_SETUP  = 3'd3,
    HI_STROBE = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Strobe counter counts down to zero; zero marks the last strobe cycle.
  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYC - 1);

  state_t      state_q, state_d;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  bmask_q;
  logic        wr_q;
  logic [3:0]  cnt_q;
  logic [15:0] rd_lo_q;
  logic [31:0] rdata_q;
  logic        strobe_last;
  logic        accept;
  logic        dq_drive;
  logic [15:0] dq_out;

  // Byte-address bits outside the 512 KB window are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:19], i_addr[1:0]};

  assign accept      = (state_q == IDLE) && (i_wren || i_rden);
  assign strobe_last = (cnt_q == 4'd0);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode, including skipping of write halves with no bytes enabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_wren) begin
          if (|i_bmask[1:0])      state_d = LO_SETUP;
          else if (|i_bmask[3:2]) state_d = HI_SETUP;
          else                    state_d = DONE;
        end else if (i_rden) begin
          state_d = LO_SETUP;
        end
      end
      LO_SETUP:  state_d = LO_STROBE;
      LO_STROBE: begin
        if (strobe_last) begin
          if (wr_q && !(|bmask_q[3:2])) state_d = DONE;
          else                          state_d = HI_SETUP;
        end
      end
      HI_SETUP:  state_d = HI_STROBE;
      HI_STROBE: if (strobe_last) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request capture on acceptance; inputs are ignored while busy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= i_addr[18:2];
      wdata_q <= i_wdata;
      bmask_q <= i_bmask;
      wr_q    <= i_wren;
    end
  end

  // Strobe-width down-counter, loaded in each setup cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                        cnt_q <= '0;
    else if (state_q == LO_SETUP || state_q == HI_SETUP) cnt_q <= CNT_LOAD;
    else if (!strobe_last)                               cnt_q <= cnt_q - 4'd1;
  end

  // Read capture: low half is staged so o_rdata changes only once, entering DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_lo_q <= '0;
      rdata_q <= '0;
    end else if (!wr_q && strobe_last) begin
      if (state_q == LO_STROBE) rd_lo_q <= io_sram_dq;
      if (state_q == HI_STROBE) rdata_q <= {io_sram_dq, rd_lo_q};
    end
  end

  // SRAM pin decode; DQ is only driven for writes, so never while OE_N is low.
  always_comb begin
    o_sram_ce_n = 1'b1;
    o_sram_we_n = 1'b1;
    o_sram_oe_n = 1'b1;
    o_sram_lb_n = 1'b1;
    o_sram_ub_n = 1'b1;
    o_sram_addr = '0;
    dq_drive    = 1'b0;
    dq_out      = '0;
    o_ack       = 1'b0;
    case (state_q)
      LO_SETUP, LO_STROBE: begin
        o_sram_ce_n = 1'b0;
        o_sram_addr = {addr_q, 1'b0};
        if (wr_q) begin
          dq_drive = 1'b1;
          dq_out   = wdata_q[15:0];
          if (state_q == LO_STROBE) begin
            o_sram_we_n = 1'b0;
            o_sram_lb_n = ~bmask_q[0];
            o_sram_ub_n = ~bmask_q[1];
          end
        end else if (state_q == LO_STROBE) begin
          o_sram_oe_n = 1'b0;
          o_sram_lb_n = 1'b0;
          o_sram_ub_n = 1'b0;
        end
      end
      HI_SETUP, HI_STROBE: begin
        o_sram_ce_n = 1'b0;
        o_sram_addr = {addr_q, 1'b1};
        if (wr_q) begin
          dq_drive = 1'b1;
          dq_out   = wdata_q[31:16];
          if (state_q == HI_STROBE) begin
            o_sram_we_n = 1'b0;
            o_sram_lb_n = ~bmask_q[2];
            o_sram_ub_n = ~bmask_q[3];
          end
        end else if (state_q == HI_STROBE) begin
          o_sram_oe_n = 1'b0;
          o_sram_lb_n = 1'b0;
          o_sram_ub_n = 1'b0;
        end
      end
      DONE:    o_ack = 1'b1;
      default: ;
    endcase
  end

  assign io_sram_dq = dq_drive ? dq_out : 16'hzzzz;
  assign o_busy     = (state_q != IDLE);
  assign o_rdata    = rdata_q;

endmodule

// File: tb/tb_sram_word_responder.sv
// tb_sram_word_responder
// Directed bench: one responder with STROBE_CYC=1 on a behavioural SRAM,
// and one with STROBE_CYC=3 on an SRAM returning (address ^ 0x5A5A).
module tb_sram_word_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // STROBE_CYC = 1 instance
  logic        rst_n, wren, rden, ack, busy, ce, we, oe, lb, ub;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  bmask;
  logic [17:0] sa;
  wire  [15:0] dq;

  // STROBE_CYC = 3 instance
  logic        rst_n3, wren3, rden3, ack3, busy3, ce3, we3, oe3, lb3, ub3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  bmask3;
  logic [17:0] sa3;
  wire  [15:0] dq3;

  sram_word_responder #(.STROBE_CYC(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .i_wren(wren), .i_rden(rden), .o_rdata(rdata), .o_ack(ack), .o_busy(busy),
    .o_sram_addr(sa), .io_sram_dq(dq), .o_sram_ce_n(ce), .o_sram_we_n(we),
    .o_sram_oe_n(oe), .o_sram_lb_n(lb), .o_sram_ub_n(ub));

  sram_word_responder #(.STROBE_CYC(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n3), .i_addr(addr3), .i_wdata(wdata3), .i_bmask(bmask3),
    .i_wren(wren3), .i_rden(rden3), .o_rdata(rdata3), .o_ack(ack3), .o_busy(busy3),
    .o_sram_addr(sa3), .io_sram_dq(dq3), .o_sram_ce_n(ce3), .o_sram_we_n(we3),
    .o_sram_oe_n(oe3), .o_sram_lb_n(lb3), .o_sram_ub_n(ub3));

  // SRAM models
  logic [15:0] mem1 [0:262143];
  assign dq  = (!ce && !oe && we) ? mem1[sa] : 16'hzzzz;
  assign dq3 = (!ce3 && !oe3 && we3) ? (sa3[15:0] ^ 16'h5A5A) : 16'hzzzz;

  // Bus observers, evaluated on pre-edge values
  int          we_cnt = 0, oe_cnt = 0, bus_viol = 0, bus_viol3 = 0;
  logic        prev_we = 1'b1, prev_oe = 1'b1, last_lb = 1'b1, last_ub = 1'b1;
  logic [17:0] last_wa = '0;
  logic [15:0] last_wd = '0;

  always @(posedge clk) begin
    if (!ce && !we) begin
      if (!lb) mem1[sa][7:0]  <= dq[7:0];
      if (!ub) mem1[sa][15:8] <= dq[15:8];
    end
    if (!we && prev_we) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= sa;
      last_wd <= dq;
      last_lb <= lb;
      last_ub <= ub;
    end
    if (!oe && prev_oe) oe_cnt <= oe_cnt + 1;
    prev_we <= we;
    prev_oe <= oe;
    if ((!oe && (u_dut.dq_drive || !we)) || (!we && !oe)) bus_viol <= bus_viol + 1;
    if (!oe3 && (u_dut3.dq_drive || !we3)) bus_viol3 <= bus_viol3 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the STROBE_CYC=1 instance; lat = edges from accepting edge to ack.
  task automatic acc1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input logic w, output int lat, output logic [31:0] rd);
    int n;
    addr = a; wdata = d; bmask = m; wren = w; rden = ~w;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; n = 1;
    while (ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("ack_seen", 32'(ack), 32'd1);
    lat = n - 1;
    rd  = rdata;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 32'd0);
  endtask

  initial begin
    int lat, n, w0, o0;
    logic [31:0] rd;
    rst_n = 1'b0; wren = 1'b0; rden = 1'b0; addr = '0; wdata = '0; bmask = '0;
    rst_n3 = 1'b0; wren3 = 1'b0; rden3 = 1'b0; addr3 = '0; wdata3 = '0; bmask3 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst_n3 = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_strobes", 32'({ce, we, oe, lb, ub}), 32'h1F);
      chk("idle_dq_z", 32'(u_dut.dq_drive), 32'd0);
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_rdata", rdata, 32'd0);
      chk("idle_addr", 32'(sa), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Full write: 0x2008 -> halfwords 0x1004/0x1005
    w0 = we_cnt;
    acc1(32'h0000_2008, 32'hDEAD_BEEF, 4'b1111, 1'b1, lat, rd);
    chk("wr_full_lat", 32'(lat), 32'd4);
    chk("wr_full_pulses", 32'(we_cnt - w0), 32'd2);
    chk("wr_full_lo_mem", 32'(mem1[18'h01004]), 32'h0000_BEEF);
    chk("wr_full_hi_mem", 32'(mem1[18'h01005]), 32'h0000_DEAD);
    chk("wr_full_last_addr", 32'(last_wa), 32'h0000_1005);
    chk("wr_full_last_dq", 32'(last_wd), 32'h0000_DEAD);
    chk("wr_full_lanes", 32'({last_ub, last_lb}), 32'd0);

    // Read back
    w0 = we_cnt; o0 = oe_cnt;
    acc1(32'h0000_2008, 32'h0, 4'b0000, 1'b0, lat, rd);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_oe_pulses", 32'(oe_cnt - o0), 32'd2);
    chk("rd_no_we", 32'(we_cnt - w0), 32'd0);

    // Address wrap above 512 KB
    acc1(32'h0008_2008, 32'h0, 4'b0000, 1'b0, lat, rd);
    chk("rd_wrap_data", rd, 32'hDEAD_BEEF);

    // High-half-only write, byte 2
    w0 = we_cnt;
    acc1(32'h0000_2008, 32'h0055_0000, 4'b0100, 1'b1, lat, rd);
    chk("wr_hi_lat", 32'(lat), 32'd2);
    chk("wr_hi_pulses", 32'(we_cnt - w0), 32'd1);
    chk("wr_hi_addr", 32'(last_wa), 32'h0000_1005);
    chk("wr_hi_lanes", 32'({last_ub, last_lb}), 32'b10);
    chk("rdata_hold_on_wr", rdata, 32'hDEAD_BEEF);
    acc1(32'h0000_2008, 32'h0, 4'b0000, 1'b0, lat, rd);
    chk("rd_after_hi", rd, 32'hDE55_BEEF);

    // Empty mask: ack right on the accepting edge, no SRAM activity
    w0 = we_cnt;
    acc1(32'h0000_2008, 32'hFFFF_FFFF, 4'b0000, 1'b1, lat, rd);
    chk("wr_none_lat", 32'(lat), 32'd0);
    chk("wr_none_pulses", 32'(we_cnt - w0), 32'd0);

    // Low-half-only write
    w0 = we_cnt;
    acc1(32'h0000_2008, 32'h0000_ABCD, 4'b0011, 1'b1, lat, rd);
    chk("wr_lo_lat", 32'(lat), 32'd2);
    chk("wr_lo_pulses", 32'(we_cnt - w0), 32'd1);
    chk("wr_lo_addr", 32'(last_wa), 32'h0000_1004);
    acc1(32'h0000_2008, 32'h0, 4'b0000, 1'b0, lat, rd);
    chk("rd_after_lo", rd, 32'hDE55_ABCD);

    // Both requests held through ack: write, then immediate re-acceptance
    w0 = we_cnt; o0 = oe_cnt;
    addr = 32'h0000_0100; wdata = 32'h1234_5678; bmask = 4'hF; wren = 1'b1; rden = 1'b1;
    @(negedge clk);
    n = 1;
    while (ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("held_lat", 32'(n - 1), 32'd4);
    addr = 32'h0000_0104; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("held_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held_reaccept", 32'(busy), 32'd1);
    rden = 1'b0;
    @(negedge clk); wren = 1'b0;
    @(negedge clk); wren = 1'b1; rden = 1'b1;
    @(negedge clk); wren = 1'b0; rden = 1'b0;
    n = 0;
    while (ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("held_ack2", 32'(ack), 32'd1);
    repeat (4) @(negedge clk);
    chk("held_quiet", 32'(busy), 32'd0);
    chk("held_pulses", 32'(we_cnt - w0), 32'd4);
    chk("held_no_read", 32'(oe_cnt - o0), 32'd0);
    chk("held_mem_80", 32'(mem1[18'h00080]), 32'h0000_5678);
    chk("held_mem_81", 32'(mem1[18'h00081]), 32'h0000_1234);
    chk("held_mem_82", 32'(mem1[18'h00082]), 32'h0000_F00D);
    chk("held_mem_83", 32'(mem1[18'h00083]), 32'h0000_CAFE);
    chk("bus_rule", 32'(bus_viol), 32'd0);

    // STROBE_CYC=3: reset during low strobe of a write
    addr3 = 32'h0000_0040; wdata3 = 32'h1111_2222; bmask3 = 4'hF; wren3 = 1'b1;
    @(negedge clk); wren3 = 1'b0;
    @(negedge clk);
    chk("s3_in_strobe", 32'(we3), 32'd0);
    rst_n3 = 1'b0;
    @(negedge clk);
    chk("s3_rst_strobes", 32'({ce3, we3, oe3, lb3, ub3}), 32'h1F);
    chk("s3_rst_dq_z", 32'(u_dut3.dq_drive), 32'd0);
    chk("s3_rst_busy", 32'(busy3), 32'd0);
    chk("s3_rst_ack", 32'(ack3), 32'd0);
    chk("s3_rst_addr", 32'(sa3), 32'd0);
    chk("s3_rst_rdata", rdata3, 32'd0);
    rst_n3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_no_ack", 32'({ack3, busy3}), 32'd0);
    end

    // STROBE_CYC=3 read: 0x10 -> halfwords 8 and 9
    addr3 = 32'h0000_0010; rden3 = 1'b1;
    @(negedge clk); rden3 = 1'b0; n = 1;
    while (ack3 !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("s3_rd_ack", 32'(ack3), 32'd1);
    chk("s3_rd_lat", 32'(n - 1), 32'd8);
    chk("s3_rd_data", rdata3, 32'h5A53_5A52);
    @(negedge clk);
    chk("s3_ack_one_cycle", 32'(ack3), 32'd0);
    chk("s3_bus_rule", 32'(bus_viol3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
